// File: rtl/rr_arbiter_16_pkg.sv
// rr_arbiter_16_pkg
//   Shared types and sizes for the 16-way round-robin arbiter:
//   arbiter state encoding, requester count, index and hold-counter widths,
//   and a helper for the wrap-around "next index" used by the picker.
package rr_arbiter_16_pkg;

  localparam int NUM_REQ     = 16;
  localparam int INDEX_WIDTH = 4;
  localparam int HOLD_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Index following idx, wrapping 15 -> 0.
  function automatic logic [INDEX_WIDTH-1:0] next_index(input logic [INDEX_WIDTH-1:0] idx);
    return idx + INDEX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/dec_4to16.sv
// dec_4to16
//   4:16 binary decoder with enable. Output is all-zero when disabled,
//   otherwise exactly the bit selected by Sel_In is set.
//   Ports:
//     Sel_In  [3:0]  encoded select value
//     En_In          decoder enable
//     Dec_Out [15:0] one-hot decoded output
module dec_4to16 (
  input  logic [3:0]  Sel_In,
  input  logic        En_In,
  output logic [15:0] Dec_Out
);

  always_comb begin
    Dec_Out = '0;
    if (En_In) Dec_Out[Sel_In] = 1'b1;
  end

endmodule

// File: rtl/rr_pick_16.sv
// rr_pick_16
//   Combinational round-robin pick: rotate the request vector so the search
//   starts just above Last_Index, priority-encode the lowest set bit, then
//   rotate the offset back into an absolute requester index.
//   Ports:
//     Request_In [15:0] request levels, bit 0 = requester 0
//     Last_Index [3:0]  most recently granted requester (lowest priority)
//     Win_Index  [3:0]  winning requester (meaningful only when Any_Req)
//     Any_Req           at least one request is set
module rr_pick_16
  import rr_arbiter_16_pkg::*;
(
  input  logic [NUM_REQ-1:0]     Request_In,
  input  logic [INDEX_WIDTH-1:0] Last_Index,
  output logic [INDEX_WIDTH-1:0] Win_Index,
  output logic                   Any_Req
);

  logic [INDEX_WIDTH-1:0] start;
  logic [NUM_REQ-1:0]     rot;
  logic [INDEX_WIDTH-1:0] off;

  always_comb begin
    start = next_index(Last_Index);
    // rot[0] is the highest-priority requester for this search.
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = Request_In[start + INDEX_WIDTH'(i)];
    end
    // Scan downward so the lowest set offset wins.
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = INDEX_WIDTH'(i);
    end
    Win_Index = start + off;
    Any_Req   = |Request_In;
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16
//   Round-robin arbiter for 16 requesters sharing a 4:16 decoded select bus.
//   IDLE arbitrates, GRANT holds one owner until Done, withdrawal or the
//   hold-time limit, GAP inserts one dead cycle for bus turnaround.
//   Parameters:
//     MAX_HOLD  max grant length in cycles (1..255), 0 = unlimited
//   Ports:
//     Clock_In               rising-edge clock
//     Reset_N_In             synchronous active-low reset
//     Request_In      [15:0] request levels, bit 0 = requester 0
//     Done_In                owner finished (only looked at in GRANT)
//     Grant_Valid_Out        grant active (decoder enable)
//     Grant_Index_Out [3:0]  current owner (decoder encoded value)
//     Grant_Out       [15:0] one-hot grant, zero when not valid
//     Timeout_Out            one-cycle pulse during the GAP that follows a
//                            hold-limit revocation
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                   Clock_In,
  input  logic                   Reset_N_In,
  input  logic [NUM_REQ-1:0]     Request_In,
  input  logic                   Done_In,
  output logic                   Grant_Valid_Out,
  output logic [INDEX_WIDTH-1:0] Grant_Index_Out,
  output logic [NUM_REQ-1:0]     Grant_Out,
  output logic                   Timeout_Out
);

  localparam int                    HOLD_LIM_INT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LIM     = HOLD_WIDTH'(HOLD_LIM_INT);
  localparam logic                  HOLD_EN      = (MAX_HOLD != 0);

  arb_state_e             state_q, state_d;
  logic                   grant_valid_q, grant_valid_d;
  logic [INDEX_WIDTH-1:0] grant_index_q, grant_index_d;
  logic [INDEX_WIDTH-1:0] last_index_q, last_index_d;
  logic [HOLD_WIDTH-1:0]  hold_cnt_q, hold_cnt_d;
  logic                   timeout_q, timeout_d;

  logic [INDEX_WIDTH-1:0] win_index;
  logic                   any_req;
  logic                   rel_done, rel_withdraw, rel_timeout;
  logic [NUM_REQ-1:0]     dec_out;

  rr_pick_16 u_pick (
    .Request_In (Request_In),
    .Last_Index (last_index_q),
    .Win_Index  (win_index),
    .Any_Req    (any_req)
  );

  // Release causes, in priority order; a timeout only counts as the cause
  // when neither Done nor withdrawal is also present.
  always_comb begin
    rel_done     = Done_In;
    rel_withdraw = ~Request_In[grant_index_q];
    rel_timeout  = HOLD_EN && (hold_cnt_q == HOLD_LIM);
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_index_d = grant_index_q;
    last_index_d  = last_index_q;
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_index_d = win_index;
          last_index_d  = win_index;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
          state_d       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (rel_done || rel_withdraw || rel_timeout) begin
          grant_valid_d = 1'b0;
          timeout_d     = ~rel_done & ~rel_withdraw;
          state_d       = ST_GAP;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HOLD_WIDTH'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        grant_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock_In) begin
    if (!Reset_N_In) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      last_index_q  <= INDEX_WIDTH'(NUM_REQ - 1);
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
      last_index_q  <= last_index_d;
      hold_cnt_q    <= hold_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  // Decoder always enabled and gated afterwards, so Grant_Out is driven
  // (never Z) and all-zero whenever no grant is active.
  dec_4to16 u_dec (
    .Sel_In  (grant_index_q),
    .En_In   (1'b1),
    .Dec_Out (dec_out)
  );

  assign Grant_Out       = dec_out & {NUM_REQ{grant_valid_q}};
  assign Grant_Valid_Out = grant_valid_q;
  assign Grant_Index_Out = grant_index_q;
  assign Timeout_Out     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Testbench for rr_arbiter_16: directed stimulus pushes expected grant
// episodes (index, length, timeout flag, idle gap before it) into a queue;
// a negedge monitor rebuilds each episode from the DUT outputs and compares.
module tb_rr_arbiter_16;

  typedef struct {
    logic [3:0] idx;
    int         len;   // 0 = don't care
    logic       to;
    int         gap;   // -1 = don't care
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, rst0_n;
  logic [15:0] req, req0;
  logic        done, done0;
  logic        gv, gv0, to, to0;
  logic [3:0]  gi, gi0;
  logic [15:0] go, go0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  bit   sb_en = 1'b1;

  always #5 clk = ~clk;

  rr_arbiter_16 #(.MAX_HOLD(4)) dut (
    .Clock_In(clk), .Reset_N_In(rst_n), .Request_In(req), .Done_In(done),
    .Grant_Valid_Out(gv), .Grant_Index_Out(gi), .Grant_Out(go), .Timeout_Out(to)
  );

  rr_arbiter_16 #(.MAX_HOLD(0)) dut0 (
    .Clock_In(clk), .Reset_N_In(rst0_n), .Request_In(req0), .Done_In(done0),
    .Grant_Valid_Out(gv0), .Grant_Index_Out(gi0), .Grant_Out(go0), .Timeout_Out(to0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] idx, input int len, input logic t, input int gap);
    exp_t e;
    e.idx = idx; e.len = len; e.to = t; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!gv && n < 50);
    if (!gv) begin
      checks++; errors++;
      $display("FAIL %s grant_valid actual=0 required=1 (no grant in 50 cycles)", nm);
    end
  endtask

  task automatic wait_fall(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (gv && n < 50);
    if (gv) begin
      checks++; errors++;
      $display("FAIL %s grant_valid actual=1 required=0 (no release in 50 cycles)", nm);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        pv = 1'b0;
  int          cur_len = 0, cur_gap = 0, low_cnt = 0;
  logic [3:0]  cur_idx = '0;
  logic [15:0] one16 = 16'h0001;

  always @(negedge clk) begin
    chk("grant_onehot",   go,  gv  ? (one16 << gi)  : 16'h0);
    chk("grant0_onehot",  go0, gv0 ? (one16 << gi0) : 16'h0);
    chk("timeout_nohold", to0, 1'b0);
    if (gv && !pv) begin
      cur_idx = gi; cur_len = 1; cur_gap = low_cnt;
    end else if (gv) begin
      cur_len++;
    end else if (pv) begin
      if (sb_en) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected grant idx actual=%0d required=none", cur_idx);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_index", cur_idx, e.idx);
          if (e.len != 0) chk("sb_length", cur_len, e.len);
          chk("sb_timeout", to, e.to);
          if (e.gap >= 0) chk("sb_gap", cur_gap, e.gap);
        end
      end
      low_cnt = 1;
    end else begin
      low_cnt++;
    end
    pv = gv;
  end

  // ---------------- fairness tracker ----------------
  int          wcnt[16];
  int          max_wait = 0;
  logic        fpv = 1'b0;
  logic [15:0] r;

  always begin
    @(posedge clk);
    r = req;
    #1;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) wcnt[i] = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (!r[i]) wcnt[i] = 0;
      if (gv && !fpv) begin
        for (int i = 0; i < 16; i++) begin
          if (i == int'(gi)) wcnt[i] = 0;
          else if (r[i]) begin
            wcnt[i]++;
            if (wcnt[i] > max_wait) max_wait = wcnt[i];
          end
        end
      end
    end
    fpv = gv;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; rst0_n = 1'b0;
    req = '0; req0 = '0; done = 1'b0; done0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", gv, 1'b0);
    chk("rst_index", gi, 4'd0);
    chk("rst_grant", go, 16'h0);
    chk("rst_timeout", to, 1'b0);
    rst_n = 1'b1; rst0_n = 1'b1;

    // single requester, Done after 2 cycles
    push(4'd0, 2, 1'b0, -1);
    req = 16'h0001;
    wait_valid("t1_grant");
    chk("t1_index", gi, 4'd0);
    @(negedge clk); done = 1'b1; req = '0;
    @(negedge clk); done = 1'b0;
    chk("t1_gap_valid", gv, 1'b0);
    @(negedge clk);
    chk("t1_idle_valid", gv, 1'b0);

    // reset, then all requesting: 0..15,0 with GAP+IDLE between grants
    rst_n = 1'b0;
    @(negedge clk);
    chk("t2_rst_valid", gv, 1'b0);
    rst_n = 1'b1;
    req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      push(4'(k % 16), 1, 1'b0, (k == 0) ? -1 : 2);
      wait_valid("t2_grant");
      done = 1'b1;
      if (k == 16) req = '0;
      @(negedge clk); done = 1'b0;
    end
    repeat (2) @(negedge clk);

    // hold limit 4 on requester 5
    push(4'd5, 4, 1'b1, -1);
    req = 16'h0020;
    wait_valid("t3_grant");
    wait_fall("t3_release");
    req = '0;
    repeat (2) @(negedge clk);

    // unlimited hold on the MAX_HOLD=0 instance
    req0 = 16'h0020;
    repeat (20) @(negedge clk);
    chk("t3b_valid_held", gv0, 1'b1);
    chk("t3b_index", gi0, 4'd5);
    done0 = 1'b1; req0 = '0;
    @(negedge clk); done0 = 1'b0;
    chk("t3b_released", gv0, 1'b0);

    // owner 3 withdraws while 9 is requesting
    push(4'd3, 2, 1'b0, -1);
    push(4'd9, 1, 1'b0, 2);
    req = 16'h0008;
    wait_valid("t4_grant3");
    @(negedge clk); req = 16'h0200;
    wait_valid("t4_grant9");
    chk("t4_index9", gi, 4'd9);
    done = 1'b1; req = '0;
    @(negedge clk); done = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-grant on 12, then 0 wins over 12
    push(4'd12, 2, 1'b0, -1);
    req = 16'h1000;
    wait_valid("t5_grant12");
    chk("t5_index12", gi, 4'd12);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", gv, 1'b0);
    chk("t5_rst_index", gi, 4'd0);
    chk("t5_rst_grant", go, 16'h0);
    chk("t5_rst_timeout", to, 1'b0);
    rst_n = 1'b1; req = 16'h1001;
    push(4'd0, 1, 1'b0, -1);
    push(4'd12, 1, 1'b0, 2);
    wait_valid("t5_grant0");
    chk("t5_index0", gi, 4'd0);
    done = 1'b1;
    @(negedge clk); done = 1'b0;
    wait_valid("t5_grant12b");
    done = 1'b1; req = '0;
    @(negedge clk); done = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    // random traffic: invariants and fairness only
    sb_en = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        int b;
        b = $urandom_range(0, 15);
        req[b] = ~req[b];
      end
      done  = ($urandom_range(0, 4) == 0);
      req0  = req;
      done0 = done;
    end
    chk("fair_max_wait_le15", (max_wait <= 15) ? 1'b1 : 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
